// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one async_fifo write port among N_REQ requesters.
// Define FIFO_WR_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [D_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] beat_nxt;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_found;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= ID_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next owner selection; loops run so the preferred candidate is assigned last
    always_comb begin
        sel_found = |req_valid;
        sel_idx   = '0;
`ifdef FIFO_WR_ARB_FIXED_PRI_EN
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) sel_idx = ID_W'(i);
        end
`else
        for (int i = int'(N_REQ); i >= 1; i--) begin
            if (req_valid[(int'(owner_q) + i) % int'(N_REQ)])
                sel_idx = ID_W'((int'(owner_q) + i) % int'(N_REQ));
        end
`endif
    end

    assign beat_nxt = beat_cnt_q + CNT_W'(1);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d    = XFER;
                    owner_d    = sel_idx;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                if (fifo_wr_en) begin
                    beat_cnt_d = beat_nxt;
                    if (req_last[owner_q] || (beat_nxt == CNT_W'(MAX_BURST)))
                        state_d = IDLE;
                end
                // Dropping valid truncates the burst, even while the FIFO is full
                if (!req_valid[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational write path from the registered owner
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state_q == XFER) begin
            req_ready[owner_q] = ~fifo_full;
            fifo_wr_en         = req_valid[owner_q] & ~fifo_full;
            fifo_wr_data       = req_data[int'(owner_q)*D_WIDTH +: D_WIDTH];
        end
    end

    assign busy     = (state_q == XFER);
    assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, D_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [1:0] exp_owner;

    fifo_wr_arbiter #(.N_REQ(4), .D_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample mid-cycle, away from the active edge
    task automatic chk(input string tag, input logic e_busy, input logic e_wen,
                       input logic [1:0] e_gid, input logic [7:0] e_data, input logic [3:0] e_rdy);
        @(negedge clk);
        cmp({tag, ".busy"},  32'(busy),         32'(e_busy));
        cmp({tag, ".wr_en"}, 32'(fifo_wr_en),   32'(e_wen));
        cmp({tag, ".grant"}, 32'(grant_id),     32'(e_gid));
        cmp({tag, ".data"},  32'(fifo_wr_data), 32'(e_data));
        cmp({tag, ".ready"}, 32'(req_ready),    32'(e_rdy));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h13121110;
        req_last  = 4'h0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst", 1'b0, 1'b0, 2'd3, 8'h00, 4'h0);
        nxt();
        reset_n = 1'b1;

`ifndef FIFO_WR_ARB_FIXED_PRI_EN
        // All four valid, no last: grants 0,1,2,3,0 with a bubble before each burst
        exp_owner = 2'd3;
        for (int g = 0; g < 5; g++) begin
            chk("rr_idle", 1'b0, 1'b0, exp_owner, 8'h00, 4'h0);
            nxt();
            exp_owner = 2'(g % 4);
            for (int b = 0; b < 4; b++) begin
                chk("rr_beat", 1'b1, 1'b1, exp_owner, 8'(8'h10 + (g % 4)), 4'(1 << (g % 4)));
                nxt();
            end
        end
        req_valid = 4'h0;
        chk("rr_end", 1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        nxt();
        exp_owner = 2'd0;
`else
        // Requesters 1 and 3 valid: fixed priority always picks 1
        req_valid = 4'b1010;
        exp_owner = 2'd3;
        for (int g = 0; g < 3; g++) begin
            chk("fp_idle", 1'b0, 1'b0, exp_owner, 8'h00, 4'h0);
            nxt();
            exp_owner = 2'd1;
            for (int b = 0; b < 4; b++) begin
                chk("fp_beat", 1'b1, 1'b1, 2'd1, 8'h11, 4'b0010);
                nxt();
            end
        end
        req_valid = 4'h0;
        chk("fp_end", 1'b0, 1'b0, 2'd1, 8'h00, 4'h0);
        nxt();
        exp_owner = 2'd1;
`endif

        // Single packet from requester 2, last on third word
        req_valid = 4'b0100;
        req_data  = 32'h00A10000;
        chk("sp_idle", 1'b0, 1'b0, exp_owner, 8'h00, 4'h0);
        nxt();
        chk("sp_b1", 1'b1, 1'b1, 2'd2, 8'hA1, 4'b0100);
        nxt();
        req_data = 32'h00A20000;
        chk("sp_b2", 1'b1, 1'b1, 2'd2, 8'hA2, 4'b0100);
        nxt();
        req_data = 32'h00A30000;
        req_last = 4'b0100;
        chk("sp_b3", 1'b1, 1'b1, 2'd2, 8'hA3, 4'b0100);
        nxt();
        req_valid = 4'h0;
        req_last  = 4'h0;
        chk("sp_done", 1'b0, 1'b0, 2'd2, 8'h00, 4'h0);
        nxt();

        // Requester 1 burst with a 3-cycle full stall after beat 2
        req_valid = 4'b0010;
        req_data  = 32'h0000B100;
        chk("fs_idle", 1'b0, 1'b0, 2'd2, 8'h00, 4'h0);
        nxt();
        chk("fs_b1", 1'b1, 1'b1, 2'd1, 8'hB1, 4'b0010);
        nxt();
        req_data = 32'h0000B200;
        chk("fs_b2", 1'b1, 1'b1, 2'd1, 8'hB2, 4'b0010);
        nxt();
        req_data  = 32'h0000B300;
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("fs_stall", 1'b1, 1'b0, 2'd1, 8'hB3, 4'h0);
            nxt();
        end
        fifo_full = 1'b0;
        chk("fs_b3", 1'b1, 1'b1, 2'd1, 8'hB3, 4'b0010);
        nxt();
        req_data = 32'h0000B400;
        chk("fs_b4", 1'b1, 1'b1, 2'd1, 8'hB4, 4'b0010);
        nxt();
        req_data = 32'h0000B500;
        chk("fs_done", 1'b0, 1'b0, 2'd1, 8'h00, 4'h0);
        req_valid = 4'h0;
        nxt();

        // Requester 0 drops valid after 2 beats; requester 3 then wins
        req_valid = 4'b0001;
        req_data  = 32'h000000C1;
        chk("vd_idle0", 1'b0, 1'b0, 2'd1, 8'h00, 4'h0);
        nxt();
        chk("vd_b1", 1'b1, 1'b1, 2'd0, 8'hC1, 4'b0001);
        nxt();
        req_data = 32'h000000C2;
        chk("vd_b2", 1'b1, 1'b1, 2'd0, 8'hC2, 4'b0001);
        nxt();
        req_valid = 4'b1000;
        req_data  = 32'hD10000C2;
        req_last  = 4'b1000;
        chk("vd_drop", 1'b1, 1'b0, 2'd0, 8'hC2, 4'b0001);
        nxt();
        chk("vd_idle1", 1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        nxt();
        chk("vd_g3", 1'b1, 1'b1, 2'd3, 8'hD1, 4'b1000);
        nxt();
        req_valid = 4'h0;
        req_last  = 4'h0;
        chk("vd_done", 1'b0, 1'b0, 2'd3, 8'h00, 4'h0);
        nxt();

        // Reset asserted mid-burst clears everything at once
        req_valid = 4'b0100;
        req_data  = 32'h00E10000;
        chk("mr_idle", 1'b0, 1'b0, 2'd3, 8'h00, 4'h0);
        nxt();
        chk("mr_b1", 1'b1, 1'b1, 2'd2, 8'hE1, 4'b0100);
        nxt();
        req_data = 32'h00E20000;
        reset_n  = 1'b0;
        chk("mr_rst", 1'b0, 1'b0, 2'd3, 8'h00, 4'h0);
        nxt();
        reset_n   = 1'b1;
        req_valid = 4'h0;
        chk("mr_after", 1'b0, 1'b0, 2'd3, 8'h00, 4'h0);
        nxt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the async FIFO between `N_REQ` requesters in the write-clock domain. Each requester presents words on a valid/ready handshake; the arbiter grants one requester at a time for a burst of at most `MAX_BURST` words, round-robin, and drives the FIFO's `wr_en`/`wr_data` while honouring `full_o`. It sits directly in front of `async_fifo`, clocked by the same clock as `wr_clk`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `D_WIDTH`, 8, data width; matches FIFO `d_width`
- `MAX_BURST`, 4, maximum words per grant (1..15)
- `clk`  in  1  write-domain clock (same net as FIFO `wr_clk`)
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester word valid
- `req_data`  in  N_REQ*D_WIDTH  requester i occupies bits [i*D_WIDTH +: D_WIDTH]
- `req_last`  in  N_REQ  marks final word of requester's packet
- `req_ready`  out  N_REQ  word accepted when valid & ready
- `fifo_full`  in  1  from FIFO `full_o`
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_wr_data`  out  D_WIDTH  to FIFO `wr_data`
- `grant_id`  out  $clog2(N_REQ)  current/last owner index
- `busy`  out  1  high in XFER state

## Operation
- States: IDLE, XFER. Registers: `state`, `owner`, `beat_cnt` (4 bits).
- IDLE: if any `req_valid`, select first set bit searching from `(owner+1) mod N_REQ` upward with wrap; load `owner`, clear `beat_cnt`, go XFER. No requester valid -> stay IDLE.
- XFER (combinational from registered `owner`):
  - `req_ready[owner] = ~fifo_full`; all other `req_ready` bits 0.
  - `fifo_wr_en = req_valid[owner] & ~fifo_full`; `fifo_wr_data = req_data[owner]`.
  - Beat = `fifo_wr_en` high; increments `beat_cnt`.
  - Go IDLE after a beat with `req_last[owner]=1`, or a beat that makes `beat_cnt == MAX_BURST`.
  - `req_valid[owner]=0` in XFER (not full) -> burst truncated, go IDLE next edge.
  - `fifo_full=1`: no beat, no ready, `beat_cnt` held, grant held; valid-drop rule still applies.
- IDLE: `req_ready`=0, `fifo_wr_en`=0, `fifo_wr_data`=0.
- `grant_id` = `owner` at all times.
- Arbiter never writes while `fifo_full`=1; `wr_en & ~full_o` gating inside the FIFO is redundant but harmless.

## Timing
- Reset values: `state`=IDLE, `owner`=N_REQ-1 (requester 0 wins first), `beat_cnt`=0; outputs `req_ready`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `grant_id`=N_REQ-1, `busy`=0.
- Request latency: valid seen in IDLE at edge k -> first possible beat in cycle k+1.
- One IDLE bubble between bursts; peak throughput MAX_BURST/(MAX_BURST+1).
- Data path zero-latency within XFER (combinational mux); FIFO registers data on the same edge.
- Reset asserted mid-burst: all state clears immediately; a word presented in that cycle is not written.
- Simultaneous `req_last` and `beat_cnt` reaching MAX_BURST: single exit to IDLE.

## Configuration
- `FIFO_WR_ARB_FIXED_PRI_EN` defined: IDLE selection is fixed priority, lowest index with `req_valid` wins regardless of `owner`; starvation of high indices permitted.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold `reset_n`=0 with all requesters valid -> `fifo_wr_en`=0, `req_ready`=0, `busy`=0, `grant_id`=N_REQ-1; release -> first grant to 0.
- Single packet: requester 2 valid with data 0xA1,0xA2,0xA3, last on 0xA3 -> one IDLE cycle, then 3 consecutive `fifo_wr_en` with those data, `grant_id`=2, then `busy`=0.
- Round-robin: all 4 valid continuously, no last -> grants 0,1,2,3,0, 4 beats each, one bubble between.
- Full stall: during requester 1 burst assert `fifo_full` for 3 cycles after beat 2 -> `fifo_wr_en`/`req_ready` low 3 cycles, grant kept, beats 3 and 4 follow, total exactly 4.
- Valid drop: requester 0 drops valid after 2 beats, requester 3 valid -> XFER exits, next grant to 3 after one IDLE cycle.
- With `FIFO_WR_ARB_FIXED_PRI_EN`: requesters 1 and 3 continuously valid -> every grant goes to 1, requester 3 never granted.
